// File: rtl/cia_sp_peer.sv
// ---------------------------------------------------------------------------
// cia_sp_peer
//   Far-end peer for a CIA serial port (SP/CNT). Receives bytes that a CIA in
//   output mode clocks out on CNT. Transmits bytes MSB first into a CIA in
//   input mode by generating CNT and SP. The CIA samples SP on rising CNT.
//
//   State table (TX FSM):
//     state   | meaning
//     --------+-----------------------------------------------------------
//     TX_IDLE | cnt_out/sp_out high, ready for a byte, RX enabled
//     TX_LOW  | cnt_out low, sp_out presents the current bit
//     TX_HIGH | cnt_out high, sp_out held so the CIA samples a stable bit
//
// Ports
//   clk       in   system clock
//   res_n     in   asynchronous active-low reset
//   cnt_in    in   CNT from the CIA
//   sp_in     in   SP from the CIA
//   cnt_out   out  CNT to the CIA, idles high
//   sp_out    out  SP to the CIA, idles high
//   tx_data   in   byte to send
//   tx_valid  in   tx_data is valid
//   tx_ready  out  transmitter can accept a byte
//   tx_done   out  one-cycle pulse at the end of the 8th bit's high phase
//   rx_data   out  last received byte
//   rx_valid  out  one-cycle pulse when rx_data updates
//   rx_abort  out  one-cycle pulse when a partial byte times out
// ---------------------------------------------------------------------------
module cia_sp_peer #(
    parameter int unsigned HALF_PERIOD = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RX_TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       cnt_in,
    input  logic       sp_in,
    output logic       cnt_out,
    output logic       sp_out,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_abort
);

    localparam logic [7:0]  HP_LOAD = 8'(HALF_PERIOD - 1);
    localparam logic [15:0] TO_LAST = 16'(RX_TIMEOUT - 1);

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LOW  = 2'd1,
        TX_HIGH = 2'd2
    } tx_state_e;

    tx_state_e  state_q, state_d;
    logic [7:0] hp_cnt_q, hp_cnt_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic       tx_done_q, tx_done_d;
    logic       tx_start;

    // ------------------------------------------------------------------
    // TX: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= TX_IDLE;
            hp_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hp_cnt_q  <= hp_cnt_d;
            tx_bit_q  <= tx_bit_d;
            tx_sh_q   <= tx_sh_d;
            tx_done_q <= tx_done_d;
        end
    end

    // ------------------------------------------------------------------
    // TX: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        hp_cnt_d  = hp_cnt_q;
        tx_bit_d  = tx_bit_q;
        tx_sh_d   = tx_sh_q;
        tx_done_d = 1'b0;
        tx_start  = 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (tx_valid) begin
                    tx_start = 1'b1;
                end
            end
            TX_LOW: begin
                if (hp_cnt_q == 8'd0) begin
                    state_d  = TX_HIGH;
                    hp_cnt_d = HP_LOAD;
                end else begin
                    hp_cnt_d = hp_cnt_q - 8'd1;
                end
            end
            TX_HIGH: begin
                if (hp_cnt_q == 8'd0) begin
                    tx_sh_d  = {tx_sh_q[6:0], 1'b0};
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_done_d = 1'b1;
                        state_d   = TX_IDLE;
                        // A waiting byte chains straight into its low phase
                        // so CNT shows no idle-high gap between bytes.
                        if (tx_valid) begin
                            tx_start = 1'b1;
                        end
                    end else begin
                        state_d  = TX_LOW;
                        hp_cnt_d = HP_LOAD;
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        if (tx_start) begin
            state_d  = TX_LOW;
            tx_sh_d  = tx_data;
            tx_bit_d = 3'd0;
            hp_cnt_d = HP_LOAD;
        end
    end

    // ------------------------------------------------------------------
    // TX: outputs
    // ------------------------------------------------------------------
    always_comb begin
        tx_ready = (state_q == TX_IDLE);
        cnt_out  = (state_q != TX_LOW);
        sp_out   = (state_q == TX_IDLE) ? 1'b1 : tx_sh_q[7];
    end

    assign tx_done = tx_done_q;

    // ------------------------------------------------------------------
    // RX: input synchronizers. Both lines use the same depth so SP stays
    // aligned with CNT. Flops reset high (the line idle level) so leaving
    // reset with CNT idle high does not look like a rising edge.
    // ------------------------------------------------------------------
    logic cnt_s, sp_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign cnt_s = cnt_in;
            assign sp_s  = sp_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] cnt_sync_q;
            logic [SYNC_STAGES-1:0] sp_sync_q;

            always_ff @(posedge clk or negedge res_n) begin
                if (!res_n) begin
                    cnt_sync_q <= '1;
                    sp_sync_q  <= '1;
                end else begin
                    cnt_sync_q[0] <= cnt_in;
                    sp_sync_q[0]  <= sp_in;
                    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                        cnt_sync_q[i] <= cnt_sync_q[i-1];
                        sp_sync_q[i]  <= sp_sync_q[i-1];
                    end
                end
            end

            assign cnt_s = cnt_sync_q[SYNC_STAGES-1];
            assign sp_s  = sp_sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // RX: shifter, bit counter, timeout
    // ------------------------------------------------------------------
    logic        cnt_prev_q;
    logic [6:0]  rx_sh_q;
    logic [2:0]  rx_bit_q;
    logic [15:0] rx_to_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        rx_abort_q;
    logic        rx_rise;

    // CNT is shared with our own transmitter, so edges only count in IDLE.
    assign rx_rise = cnt_s & ~cnt_prev_q & (state_q == TX_IDLE);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_prev_q <= 1'b1;
            rx_sh_q    <= '0;
            rx_bit_q   <= '0;
            rx_to_q    <= '0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_abort_q <= 1'b0;
        end else begin
            cnt_prev_q <= cnt_s;
            rx_valid_q <= 1'b0;
            rx_abort_q <= 1'b0;

            if (tx_start) begin
                rx_bit_q <= '0;
                rx_to_q  <= '0;
            end else if (rx_rise) begin
                rx_sh_q  <= {rx_sh_q[5:0], sp_s};
                rx_bit_q <= rx_bit_q + 3'd1;
                rx_to_q  <= '0;
                if (rx_bit_q == 3'd7) begin
                    rx_data_q  <= {rx_sh_q, sp_s};
                    rx_valid_q <= 1'b1;
                end
            end else if (rx_bit_q != 3'd0) begin
                if (rx_to_q == TO_LAST) begin
                    rx_bit_q   <= '0;
                    rx_sh_q    <= '0;
                    rx_to_q    <= '0;
                    rx_abort_q <= 1'b1;
                end else begin
                    rx_to_q <= rx_to_q + 16'd1;
                end
            end else begin
                rx_to_q <= '0;
            end
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_abort = rx_abort_q;

endmodule

// File: tb/tb_cia_sp_peer.sv
module tb_cia_sp_peer;

    localparam int HP = 4;

    logic       clk;
    logic       res_n;
    logic       cnt_in;
    logic       sp_in;
    logic       cnt_out;
    logic       sp_out;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_abort;

    int n_checks = 0;
    int n_pass   = 0;
    int rxv_cnt  = 0;
    int rxa_cnt  = 0;
    int done_cnt = 0;

    logic cap_cnt  [0:199];
    logic cap_sp   [0:199];
    logic cap_rdy  [0:199];
    logic cap_done [0:199];

    cia_sp_peer #(
        .HALF_PERIOD(HP),
        .SYNC_STAGES(2),
        .RX_TIMEOUT (16)
    ) dut (
        .clk     (clk),
        .res_n   (res_n),
        .cnt_in  (cnt_in),
        .sp_in   (sp_in),
        .cnt_out (cnt_out),
        .sp_out  (sp_out),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_done (tx_done),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_abort(rx_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rxv_cnt++;
        if (rx_abort === 1'b1) rxa_cnt++;
        if (tx_done === 1'b1)  done_cnt++;
    end

    // Expected {cnt_out, sp_out} at the sample following edge j of a TX run.
    function automatic logic [1:0] exp_wave(input int j, input int nbytes,
                                            input logic [7:0] d0, input logic [7:0] d1);
        int byte_len;
        int b;
        int w;
        logic [7:0] d;
        byte_len = 16 * HP;
        b = j / byte_len;
        w = j % byte_len;
        if (b >= nbytes) return 2'b11;
        d = (b == 0) ? d0 : d1;
        return {logic'((w % (2 * HP)) >= HP), d[7 - w / (2 * HP)]};
    endfunction

    // Presents d0 so it is accepted at edge 0, optionally holds tx_valid with
    // d1 for back-to-back, and records outputs after edges 0..n-1.
    task automatic run_tx(input logic [7:0] d0, input bit two,
                          input logic [7:0] d1, input int n);
        @(posedge clk); #1;
        tx_data  = d0;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        if (two) tx_data = d1;
        else     tx_valid = 1'b0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            cap_cnt[j]  = cnt_out;
            cap_sp[j]   = sp_out;
            cap_rdy[j]  = tx_ready;
            cap_done[j] = tx_done;
            if (two && j == 16 * HP) tx_valid = 1'b0;
        end
    endtask

    task automatic send_rx_bits(input logic [7:0] d, input int nbits,
                                input int lo, input int hi);
        for (int i = 0; i < nbits; i++) begin
            cnt_in = 1'b0;
            sp_in  = d[7 - i];
            repeat (lo) @(negedge clk);
            cnt_in = 1'b1;
            repeat (hi) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        cnt_in   = 1'b1;
        sp_in    = 1'b1;
        res_n    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({cnt_out, sp_out, tx_ready, tx_done} !== 4'b1110)
            $display("FAIL reset_tx_outs: got %b want 1110", {cnt_out, sp_out, tx_ready, tx_done});
        else n_pass++;
        n_checks++;
        if ({rx_data, rx_valid, rx_abort} !== 10'h000)
            $display("FAIL reset_rx_outs: got %h/%b/%b want 00/0/0", rx_data, rx_valid, rx_abort);
        else n_pass++;
        res_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if ({cnt_out, sp_out, tx_ready, rx_valid, rx_abort} !== 5'b11100)
            $display("FAIL post_reset_idle: got %b want 11100",
                     {cnt_out, sp_out, tx_ready, rx_valid, rx_abort});
        else n_pass++;
    endtask

    task automatic test_tx_single();
        int errs_c, errs_s, first_bad, falls, bad_len, run, ndone;
        logic prev;
        logic [1:0] e;
        run_tx(8'hA5, 1'b0, 8'h00, 72);
        errs_c = 0; errs_s = 0; first_bad = -1;
        for (int j = 0; j < 72; j++) begin
            e = exp_wave(j, 1, 8'hA5, 8'h00);
            if (cap_cnt[j] !== e[1]) begin errs_c++; if (first_bad < 0) first_bad = j; end
            if (cap_sp[j]  !== e[0]) begin errs_s++; if (first_bad < 0) first_bad = j; end
        end
        n_checks++;
        if (errs_c != 0) $display("FAIL a5_cnt_wave: %0d bad samples (first %0d) want 0", errs_c, first_bad);
        else n_pass++;
        n_checks++;
        if (errs_s != 0) $display("FAIL a5_sp_wave: %0d bad samples (first %0d) want 0", errs_s, first_bad);
        else n_pass++;
        falls = 0; bad_len = 0; run = 0; prev = 1'b1;
        for (int j = 0; j < 72; j++) begin
            if (prev === 1'b1 && cap_cnt[j] === 1'b0) falls++;
            if (cap_cnt[j] === 1'b0) run++;
            else begin
                if (run != 0 && run != HP) bad_len++;
                run = 0;
            end
            prev = cap_cnt[j];
        end
        n_checks++;
        if (falls != 8 || bad_len != 0)
            $display("FAIL a5_low_pulses: got %0d pulses %0d bad lengths want 8/0", falls, bad_len);
        else n_pass++;
        errs_c = 0;
        for (int j = 0; j < 64; j++) if (cap_rdy[j] !== 1'b0) errs_c++;
        n_checks++;
        if (errs_c != 0 || cap_rdy[64] !== 1'b1)
            $display("FAIL a5_tx_ready: %0d high during byte, ready@64=%b want 0/1", errs_c, cap_rdy[64]);
        else n_pass++;
        ndone = 0;
        for (int j = 0; j < 72; j++) if (cap_done[j] === 1'b1) ndone++;
        n_checks++;
        if (cap_done[64] !== 1'b1 || ndone != 1)
            $display("FAIL a5_tx_done: done@64=%b count=%0d want 1/1", cap_done[64], ndone);
        else n_pass++;
    endtask

    task automatic test_rx_byte();
        int v0, a0;
        #1;
        v0 = rxv_cnt; a0 = rxa_cnt;
        send_rx_bits(8'h3C, 7, 6, 6);
        cnt_in = 1'b0;
        sp_in  = 1'b0;
        repeat (6) @(negedge clk);
        cnt_in = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (rx_valid !== 1'b0) $display("FAIL rx_lat_k: rx_valid=%b want 0", rx_valid);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (rx_valid !== 1'b0) $display("FAIL rx_lat_k1: rx_valid=%b want 0", rx_valid);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h3C)
            $display("FAIL rx_lat_k2: rx_valid=%b rx_data=%h want 1/3c", rx_valid, rx_data);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (rx_valid !== 1'b0) $display("FAIL rx_pulse_width: rx_valid=%b want 0", rx_valid);
        else n_pass++;
        repeat (4) @(negedge clk); #1;
        n_checks++;
        if (rxv_cnt - v0 != 1 || rxa_cnt - a0 != 0 || rx_data !== 8'h3C)
            $display("FAIL rx_3c: valids=%0d aborts=%0d data=%h want 1/0/3c",
                     rxv_cnt - v0, rxa_cnt - a0, rx_data);
        else n_pass++;
    endtask

    task automatic test_rx_timeout();
        int v0, a0;
        v0 = rxv_cnt; a0 = rxa_cnt;
        send_rx_bits(8'hA0, 3, 6, 6);
        repeat (20) @(negedge clk); #1;
        n_checks++;
        if (rxa_cnt - a0 != 1 || rxv_cnt - v0 != 0 || rx_data !== 8'h3C)
            $display("FAIL rx_timeout: aborts=%0d valids=%0d data=%h want 1/0/3c",
                     rxa_cnt - a0, rxv_cnt - v0, rx_data);
        else n_pass++;
        v0 = rxv_cnt; a0 = rxa_cnt;
        send_rx_bits(8'h81, 8, 6, 6);
        repeat (4) @(negedge clk); #1;
        n_checks++;
        if (rxv_cnt - v0 != 1 || rxa_cnt - a0 != 0 || rx_data !== 8'h81)
            $display("FAIL rx_after_abort: valids=%0d aborts=%0d data=%h want 1/0/81",
                     rxv_cnt - v0, rxa_cnt - a0, rx_data);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int errs, first_bad, ndone;
        logic [1:0] e;
        run_tx(8'h01, 1'b1, 8'hFF, 136);
        errs = 0; first_bad = -1;
        for (int j = 0; j < 136; j++) begin
            e = exp_wave(j, 2, 8'h01, 8'hFF);
            if ({cap_cnt[j], cap_sp[j]} !== e) begin errs++; if (first_bad < 0) first_bad = j; end
        end
        n_checks++;
        if (errs != 0) $display("FAIL b2b_wave: %0d bad samples (first %0d) want 0", errs, first_bad);
        else n_pass++;
        n_checks++;
        if (cap_cnt[64] !== 1'b0 || cap_sp[64] !== 1'b1)
            $display("FAIL b2b_boundary: cnt@64=%b sp@64=%b want 0/1", cap_cnt[64], cap_sp[64]);
        else n_pass++;
        ndone = 0;
        for (int j = 0; j < 136; j++) if (cap_done[j] === 1'b1) ndone++;
        n_checks++;
        if (ndone != 2 || cap_done[64] !== 1'b1 || cap_done[128] !== 1'b1 || cap_rdy[128] !== 1'b1)
            $display("FAIL b2b_done: count=%0d done@64=%b done@128=%b rdy@128=%b want 2/1/1/1",
                     ndone, cap_done[64], cap_done[128], cap_rdy[128]);
        else n_pass++;
    endtask

    task automatic test_rx_during_tx();
        int v0, a0, errs;
        logic [1:0] e;
        #1;
        v0 = rxv_cnt; a0 = rxa_cnt;
        fork
            run_tx(8'h55, 1'b0, 8'h00, 100);
            begin
                @(posedge clk);
                @(posedge clk); #2;
                for (int i = 0; i < 8; i++) begin
                    cnt_in = 1'b0;
                    sp_in  = i[0];
                    repeat (3) @(negedge clk);
                    cnt_in = 1'b1;
                    repeat (3) @(negedge clk);
                end
            end
        join
        #1;
        errs = 0;
        for (int j = 0; j < 100; j++) begin
            e = exp_wave(j, 1, 8'h55, 8'h00);
            if ({cap_cnt[j], cap_sp[j]} !== e) errs++;
        end
        n_checks++;
        if (errs != 0) $display("FAIL rxtx_wave: %0d bad samples want 0", errs);
        else n_pass++;
        n_checks++;
        if (rxv_cnt - v0 != 0 || rxa_cnt - a0 != 0 || rx_data !== 8'h81)
            $display("FAIL rxtx_ignored: valids=%0d aborts=%0d data=%h want 0/0/81",
                     rxv_cnt - v0, rxa_cnt - a0, rx_data);
        else n_pass++;
    endtask

    task automatic test_reset_mid_tx();
        int d0, errs, ndone;
        logic [1:0] e;
        run_tx(8'hE0, 1'b0, 8'h00, 27);
        #1;
        d0 = done_cnt;
        n_checks++;
        if (cnt_out !== 1'b0 || sp_out !== 1'b0)
            $display("FAIL midtx_bit3: cnt=%b sp=%b want 0/0", cnt_out, sp_out);
        else n_pass++;
        res_n = 1'b0;
        #1;
        n_checks++;
        if ({cnt_out, sp_out, tx_ready, tx_done} !== 4'b1110 || rx_data !== 8'h00)
            $display("FAIL midtx_async_reset: outs=%b rx_data=%h want 1110/00",
                     {cnt_out, sp_out, tx_ready, tx_done}, rx_data);
        else n_pass++;
        repeat (2) @(negedge clk);
        res_n = 1'b1;
        repeat (80) @(negedge clk); #1;
        n_checks++;
        if (done_cnt != d0) $display("FAIL midtx_no_done: done pulses=%0d want 0", done_cnt - d0);
        else n_pass++;
        run_tx(8'hC3, 1'b0, 8'h00, 70);
        errs = 0; ndone = 0;
        for (int j = 0; j < 70; j++) begin
            e = exp_wave(j, 1, 8'hC3, 8'h00);
            if ({cap_cnt[j], cap_sp[j]} !== e) errs++;
            if (cap_done[j] === 1'b1) ndone++;
        end
        n_checks++;
        if (errs != 0 || ndone != 1 || cap_done[64] !== 1'b1)
            $display("FAIL c3_after_reset: %0d bad samples, %0d done, done@64=%b want 0/1/1",
                     errs, ndone, cap_done[64]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_rx_byte();
        test_rx_timeout();
        test_back_to_back();
        test_rx_during_tx();
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cia_sp_peer.md
# cia_sp_peer

Synchronous serial peer for the CIA serial port (SP/CNT pair). It is the far end of the link. It shifts in bytes that a CIA in output mode clocks out on CNT. It also generates CNT and SP to shift bytes into a CIA in input mode, MSB first, with the CIA sampling SP on rising CNT. It sits on the board-level side of the CIA: keyboard/fast-serial adapters, test fixtures, and CIA-to-CIA bridges.

## Interface
- HALF_PERIOD, 4: clk cycles per CNT half-period when transmitting; legal range 2..255.
- SYNC_STAGES, 2: synchronizer flops on cnt_in and sp_in; legal range 0..3.
- RX_TIMEOUT, 1024: clk cycles without a CNT rising edge after which a partial receive byte is discarded; legal range 16..65535.

- clk  in  1  system clock; all logic on posedge.
- res_n  in  1  reset; asynchronous, active-low.
- cnt_in  in  1  CNT from the CIA (its cnt_out).
- sp_in  in  1  SP from the CIA (its sp_out).
- cnt_out  out  1  CNT to the CIA (its cnt_in); idles high.
- sp_out  out  1  SP to the CIA (its sp_in); idles high.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter can accept a byte.
- tx_done  out  1  one-cycle pulse when the 8th bit's high phase completes.
- rx_data  out  8  last received byte; held until the next byte completes.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- rx_abort  out  1  one-cycle pulse when a partial byte is discarded on timeout.

## Operation
- Reset (async, any state) sets:
  - cnt_out=1, sp_out=1, tx_ready=1, tx_done=0;
  - rx_data=8'h00, rx_valid=0, rx_abort=0;
  - all counters and shift registers to 0, TX FSM to IDLE.
  - Reset in mid-byte drops the byte and produces no tx_done.
- TX FSM has three states: IDLE, LOW, HIGH.
  - IDLE: tx_ready=1, cnt_out=1, sp_out=1. When tx_valid&tx_ready: load shifter with tx_data, bit counter=0, go to LOW.
  - LOW: cnt_out=0, sp_out=shifter[7]. Stay HALF_PERIOD cycles, then go to HIGH.
  - HIGH: cnt_out=1, sp_out held. Stay HALF_PERIOD cycles. At exit, shift left and increment the bit counter.
    - Bit counter was 7: pulse tx_done and go to IDLE.
    - Otherwise: go to LOW.
- RX path, input conditioning:
  - cnt_in and sp_in each pass through SYNC_STAGES flops (same depth, so they stay aligned).
  - Rising edge = synced cnt high while a previous-value register is low.
- RX path, per rising edge:
  - Shift rx shifter left, inserting synced sp.
  - Increment the 3-bit rx bit counter (wraps 7→0).
  - On the edge where the counter was 7: rx_data <= {shifter[6:0], sp} and pulse rx_valid.
- RX is disabled while the TX FSM is not IDLE.
  - CNT is a shared wire, so edges are ignored during TX.
  - The rx bit counter and timeout counter clear when TX starts.
- RX timeout:
  - The counter runs while the rx bit counter is ≠0 and clears on each rising edge.
  - On reaching RX_TIMEOUT: clear the bit counter and shifter, pulse rx_abort. rx_data is unchanged.
- No receive buffering. A new byte overwrites rx_data. The consumer must capture on rx_valid.

## Timing
- Clock edge 0 accepts a byte (tx_valid&tx_ready sampled high).
  - From edge 0: cnt_out=0, sp_out=tx_data[7], tx_ready=0.
  - Bit n (n=0..7) low phase starts at edge 2·n·HALF_PERIOD; its high phase starts HALF_PERIOD edges later.
- tx_done is high for the one cycle after edge 16·HALF_PERIOD.
  - tx_ready is 1 in that same cycle.
  - A byte held on tx_valid is accepted at edge 16·HALF_PERIOD.
  - Its cnt_out falls at that edge, so there is no idle-high gap between bytes.
- sp_out changes only at the LOW entry. It is stable for the whole HIGH phase, so the CIA's rising-edge sample is safe.
- RX latency: k is the first clk edge that samples raw cnt_in high.
  - Shift and rx_valid register at edge k+SYNC_STAGES.
  - rx_valid is high in the following cycle.
  - sp_in must be stable from edge k−1 to k+1.
- Minimum CNT high or low time accepted by RX: 2 clk cycles.

## Test plan
- TX, HALF_PERIOD=4, tx_data=8'hA5:
  - sp_out per bit is 1,0,1,0,0,1,0,1.
  - Exactly 8 cnt_out low pulses, each 4 cycles.
  - tx_done one cycle after edge 64; tx_ready low for edges 0..63.
- RX, SYNC_STAGES=2, 8 CNT pulses (6 low/6 high) carrying 8'h3C MSB first:
  - rx_valid is a single pulse, rx_data=8'h3C.
  - Pulse lands 2 edges after the 8th cnt_in rise is sampled (edge k+2), high the following cycle.
- RX timeout, RX_TIMEOUT=16:
  - Send 3 bits, idle 20 cycles: rx_abort pulses, rx_data unchanged.
  - Then send 8'h81: rx_valid with rx_data=8'h81.
- Back-to-back TX: tx_valid held with 8'h01 then 8'hFF.
  - Second byte accepted at edge 16·HALF_PERIOD.
  - cnt_out stays low across the boundary; two tx_done pulses.
- RX during TX: toggle cnt_in 8 times while transmitting 8'h55.
  - No rx_valid, no rx_abort; TX waveform unaffected.
- Reset mid-TX: drop res_n during bit 3.
  - cnt_out=1, sp_out=1, tx_ready=1 before the next clk edge.
  - No tx_done; after release, a new 8'hC3 transmits correctly.
